// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the serial link: word width, bit order and the
// output-register state encoding used by the SIPO receiver.
package sipo_deserializer_pkg;

   // Word width shared by the PISO transmitter and the SIPO receiver.
   localparam int SER_WORD_WIDTH = 4;

   // The link carries bit 0 of each word first.
   localparam bit SER_LSB_FIRST = 1'b1;

   // Output register occupancy.
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

endpackage : sipo_deserializer_pkg

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter that assemble serial bits into a word.
// word_done pulses combinationally on the accepted bit that completes a
// word; word then carries the completed value with that bit in the MSB.
module sipo_shift_core #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             clear,
   output logic             word_done,
   output logic [WIDTH-1:0] word,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next shift/count state: clear wins over an incoming bit, gaps hold state.
   always_comb begin
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      word_done = 1'b0;
      word      = {sin, shreg_q[WIDTH-1:1]};
      if (clear) begin
         shreg_d = '0;
         cnt_d   = '0;
      end else if (sin_valid) begin
         // New bit enters at the MSB so the first bit lands in bit 0.
         shreg_d = {sin, shreg_q[WIDTH-1:1]};
         if (cnt_q == LAST_CNT) begin
            cnt_d     = '0;
            word_done = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Shift register and counter flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bit_cnt = cnt_q;

endmodule : sipo_shift_core

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: assembles LSB-first serial words and
// holds each completed word in a valid/ready output register with a sticky
// overrun flag for words dropped while the register was still occupied.
module sipo_deserializer
   import sipo_deserializer_pkg::*;
#(
   parameter int WIDTH = SER_WORD_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sin,
   input  logic                     sin_valid,
   input  logic                     clear,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic [$clog2(WIDTH)-1:0] bit_cnt,
   output logic                     overrun
);

   localparam int CNT_W = $clog2(WIDTH);

   logic             word_done;
   logic [WIDTH-1:0] word;

   out_state_e       state_q, state_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             overrun_q, overrun_d;

   sipo_shift_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .sin_valid (sin_valid),
      .clear     (clear),
      .word_done (word_done),
      .word      (word),
      .bit_cnt   (bit_cnt)
   );

   // Output register next state: load, consume, or drop-and-flag a word.
   always_comb begin
      state_d   = state_q;
      dout_d    = dout_q;
      overrun_d = overrun_q;
      case (state_q)
         OUT_EMPTY: begin
            // dout_ready is ignored while nothing is pending.
            if (word_done) begin
               dout_d  = word;
               state_d = OUT_FULL;
            end
         end
         OUT_FULL: begin
            if (word_done) begin
               if (dout_ready) begin
                  // Consumer takes the old word as the new one arrives.
                  dout_d = word;
               end else begin
                  overrun_d = 1'b1;
               end
            end else if (dout_ready) begin
               state_d = OUT_EMPTY;
            end
         end
         default: state_d = OUT_EMPTY;
      endcase
      // word_done is already suppressed during clear, so no new overrun here.
      if (clear) begin
         overrun_d = 1'b0;
      end
   end

   // Output register, occupancy and overrun flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= OUT_EMPTY;
         dout_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dout_q    <= dout_d;
         overrun_q <= overrun_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = (state_q == OUT_FULL);
   assign overrun    = overrun_q;

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed scenarios followed by
// random traffic, compared against a word-level reference model.
module tb_sipo_deserializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sin = 1'b0;
   logic         sin_valid = 1'b0;
   logic         clear = 1'b0;
   logic         dout_ready = 1'b0;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic [1:0]   bit_cnt;
   logic         overrun;

   int tests = 0;
   int fails = 0;

   // Reference model: bits collected by position, pending word, flags.
   int           m_cnt;
   logic [W-1:0] m_acc;
   logic [W-1:0] m_dout;
   logic         m_valid;
   logic         m_ovr;

   sipo_deserializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .sin_valid  (sin_valid),
      .clear      (clear),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .bit_cnt    (bit_cnt),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt   = 0;
      m_acc   = '0;
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_step(input logic s, input logic sv, input logic clr, input logic rdy);
      logic [W-1:0] w;
      logic         done;
      done = sv && !clr && (m_cnt == W - 1);
      w = m_acc;
      w[W-1] = s;
      if (done) begin
         if (!m_valid || rdy) begin
            m_dout  = w;
            m_valid = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      if (clr) begin
         m_cnt = 0;
         m_acc = '0;
         m_ovr = 1'b0;
      end else if (sv) begin
         m_acc[m_cnt] = s;
         m_cnt = (m_cnt + 1) % W;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".dout"},       32'(dout),       32'(m_dout));
      check({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
      check({tag, ".bit_cnt"},    32'(bit_cnt),    32'(m_cnt));
      check({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
   endtask

   // One clock: drive inputs, let the edge happen, update model, compare.
   task automatic cyc(input string tag, input logic s, input logic sv, input logic clr, input logic rdy);
      sin        = s;
      sin_valid  = sv;
      clear      = clr;
      dout_ready = rdy;
      @(posedge clk);
      model_step(s, sv, clr, rdy);
      #1;
      check_all(tag);
   endtask

   task automatic send_word(input string tag, input logic [W-1:0] v, input logic rdy);
      for (int i = 0; i < W; i++) cyc(tag, v[i], 1'b1, 1'b0, rdy);
   endtask

   initial begin
      model_reset();
      // Reset state
      @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      // Async reset mid-word, then 1,0,1,1 -> 4'b1101
      cyc("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("pre_rst", 1'b0, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      rst = 1'b0;
      send_word("post_rst", 4'b1101, 1'b0);
      check("post_rst_word", 32'(dout), 32'hD);
      cyc("drain", 1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back 0xA then 0x5 with dout_ready held high
      send_word("b2b_a", 4'hA, 1'b1);
      check("b2b_a_word", 32'(dout), 32'hA);
      check("b2b_a_vld", 32'(dout_valid), 32'h1);
      send_word("b2b_5", 4'h5, 1'b1);
      check("b2b_5_word", 32'(dout), 32'h5);
      check("b2b_5_vld", 32'(dout_valid), 32'h1);
      check("b2b_ovr", 32'(overrun), 32'h0);
      cyc("drain", 1'b0, 1'b0, 1'b0, 1'b1);

      // Gaps: 1,1, three idle cycles, 0,0 -> 0x3
      cyc("gap", 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("gap", 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc("gap_idle", 1'b0, 1'b0, 1'b0, 1'b0);
         check("gap_hold_cnt", 32'(bit_cnt), 32'h2);
      end
      cyc("gap", 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("gap", 1'b0, 1'b1, 1'b0, 1'b0);
      check("gap_word", 32'(dout), 32'h3);
      cyc("drain", 1'b0, 1'b0, 1'b0, 1'b1);

      // Overrun: 0x3 then 0xC without ready, then clear
      send_word("ovr_3", 4'h3, 1'b0);
      send_word("ovr_c", 4'hC, 1'b0);
      check("ovr_word", 32'(dout), 32'h3);
      check("ovr_flag", 32'(overrun), 32'h1);
      cyc("ovr_clear", 1'b0, 1'b0, 1'b1, 1'b0);
      check("clr_ovr", 32'(overrun), 32'h0);
      check("clr_keeps_vld", 32'(dout_valid), 32'h1);

      // Simultaneous completion and consume: 0x3 pending, 0xF arrives
      cyc("simul", 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("simul", 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("simul", 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("simul", 1'b1, 1'b1, 1'b0, 1'b1);
      check("simul_word", 32'(dout), 32'hF);
      check("simul_vld", 32'(dout_valid), 32'h1);
      check("simul_ovr", 32'(overrun), 32'h0);
      cyc("drain", 1'b0, 1'b0, 1'b0, 1'b1);

      // Clear priority over sin_valid after 3 bits
      cyc("clrp", 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("clrp", 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("clrp", 1'b1, 1'b1, 1'b0, 1'b0);
      cyc("clrp_clr", 1'b1, 1'b1, 1'b1, 1'b0);
      check("clrp_cnt", 32'(bit_cnt), 32'h0);
      send_word("clrp_word", 4'h6, 1'b0);
      check("clrp_fresh", 32'(dout), 32'h6);
      cyc("drain", 1'b0, 1'b0, 1'b0, 1'b1);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         cyc("rand", 1'($urandom), ($urandom_range(3) != 0), ($urandom_range(19) == 0),
             1'($urandom));
      end

      // Async reset during random traffic
      cyc("rand_pre", 1'b1, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      model_reset();
      check_all("rand_rst");
      rst = 1'b0;
      send_word("rand_post", 4'h9, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_sipo_deserializer
